// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared count width, FSM state codes, modulo codes and limits for counter_ctrl
package counter_ctrl_pkg;
    localparam int CW = 14;
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t PAUSE = 2'd2;
    localparam logic [1:0] MOD_MAX  = 2'b00;
    localparam logic [1:0] MOD_99   = 2'b01;
    localparam logic [1:0] MOD_999  = 2'b10;
    localparam logic [1:0] MOD_1999 = 2'b11;
    localparam logic [CW-1:0] LIM_99   = 14'd99;
    localparam logic [CW-1:0] LIM_999  = 14'd999;
    localparam logic [CW-1:0] LIM_1999 = 14'd1999;
    function automatic logic [CW-1:0] limit_of(input logic [1:0] mod, input logic [CW-1:0] max_value);
        return mod == MOD_99 ? LIM_99 : mod == MOD_999 ? LIM_999 : mod == MOD_1999 ? LIM_1999 : max_value;
    endfunction
endpackage

// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if: control-to-counter link (tick, clear, modulo select, status, count feedback)
interface counter_ctrl_if;
    import counter_ctrl_pkg::*;
    logic [CW-1:0] count;
    logic tick_en;
    logic count_clr;
    logic [1:0] mod_select;
    logic running;
    logic wrap;
    modport master(input count, output tick_en, count_clr, mod_select, running, wrap);
    modport slave(output count, input tick_en, count_clr, mod_select, running, wrap);
endinterface

// File: rtl/counter_ctrl_key_event.sv
// key_event: 2-flop synchronizer, optional debounce (COUNTER_CTRL_DEBOUNCE_EN), 1->0 press pulse
module key_event #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);
    logic [1:0] sync;
    logic lvl;
    logic lvl_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) sync <= 2'b11;
        else sync <= {sync[0], key_n};
`ifdef COUNTER_CTRL_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_nxt;
    logic raw_q;
    // cnt is the run length of identical synchronized samples; any change restarts it at 1
    assign cnt_nxt = sync[1] != raw_q ? DW'(1) : cnt == DMAX ? cnt : cnt + 1'b1;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt   <= '0;
            raw_q <= 1'b1;
            lvl   <= 1'b1;
        end else begin
            raw_q <= sync[1];
            cnt   <= cnt_nxt;
            if (cnt_nxt == DMAX) lvl <= sync[1];
        end
`else
    assign lvl = sync[1];
`endif
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) lvl_q <= 1'b1;
        else lvl_q <= lvl;
    assign press = lvl_q & ~lvl;
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: key-driven IDLE/RUN/PAUSE sequencer issuing the prescaled count tick, clear and wrap flag.
// Define COUNTER_CTRL_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable samples on each key.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int PRESCALE        = 50_000_000,
    parameter int MAX_VALUE       = 9999,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           key_run_n,
    input  logic           key_clr_n,
    input  logic [1:0]     mod_sw,
    counter_ctrl_if.master bus
);
    localparam int PW = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PTOP = PW'(PRESCALE - 1);
    state_t state;
    logic [PW-1:0] psc;
    logic run_evt;
    logic clr_evt;
    logic count_clr;
    logic tick;
    logic [1:0] mod_select;
    key_event #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
        .clk(clk), .reset_n(reset_n), .key_n(key_run_n), .press(run_evt)
    );
    key_event #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk(clk), .reset_n(reset_n), .key_n(key_clr_n), .press(clr_evt)
    );
    // every RUN cycle advances the prescaler, including the one that pauses, so resume loses no tick
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state      <= IDLE;
            psc        <= '0;
            count_clr  <= 1'b0;
            mod_select <= MOD_MAX;
        end else begin
            count_clr <= clr_evt;
            if (state == IDLE) mod_select <= mod_sw;
            if (clr_evt) begin
                state <= IDLE;
                psc   <= '0;
            end else begin
                if (state == RUN) psc <= psc == PTOP ? '0 : psc + 1'b1;
                if (run_evt) state <= state == RUN ? PAUSE : RUN;
            end
        end
    assign tick           = state == RUN && psc == PTOP;
    assign bus.tick_en    = tick;
    assign bus.wrap       = tick && bus.count >= limit_of(mod_select, CW'(MAX_VALUE));
    assign bus.count_clr  = count_clr;
    assign bus.mod_select = mod_select;
    assign bus.running    = state == RUN;
endmodule
